// File: rtl/delay_meter_pkg.sv
// Shared types and default sizing for the delay meter.
package delay_meter_pkg;

   // Per-sample counter width; the largest recordable sample is 2**CNT_WIDTH-1.
   localparam int unsigned CNT_WIDTH_DEF   = 8;
   // log2 of the number of samples averaged per measurement.
   localparam int unsigned NAVG_LOG2_DEF   = 4;
   // Synchronizer depth used on both asynchronous inputs.
   localparam int unsigned SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_REF,
      COUNT,
      DONE
   } state_t;

endpackage

// File: rtl/delay_meter_edge_sync.sv
// N-stage synchronizer followed by a rising-edge detector.
// A rise is reported only after the synchronized level has really been seen
// low once since reset, so a level that is already high is not an edge.
module edge_sync
   import delay_meter_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] fill_q;
   logic              prev_q;
   logic              armed_q;
   logic              level;

   assign level = sync_q[STAGES-1];

   // Shift the input through the synchronizer; fill_q marks when the last
   // stage holds sampled data rather than its reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         fill_q  <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= (sync_q << 1) | STAGES'(din);
         fill_q  <= (fill_q << 1) | STAGES'(1'b1);
         prev_q  <= level;
         armed_q <= armed_q | (fill_q[STAGES-1] & ~level);
      end
   end

   assign rise = level & ~prev_q & armed_q;

endmodule

// File: rtl/delay_meter.sv
// Averaged delay measurement between a reference signal and its delayed copy.
// Each sample counts clk cycles from a ref rising edge to the following dly
// rising edge; 2**NAVG_LOG2 samples are summed into delay_sum.
module delay_meter
   import delay_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned NAVG_LOG2   = NAVG_LOG2_DEF,
   parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          ref_in,
   input  logic                          dly_in,
   output logic [CNT_WIDTH+NAVG_LOG2-1:0] delay_sum,
   output logic                          valid,
   output logic                          busy,
   output logic                          timeout
);

   localparam int unsigned SUM_W = CNT_WIDTH + NAVG_LOG2;

   state_t               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [SUM_W-1:0]     acc_q;
   logic [NAVG_LOG2-1:0] idx_q;
   logic                 idx_last;
   logic                 cnt_max;
   logic                 ref_rise;
   logic                 dly_rise;

   // Identical paths keep the relative timing of the two inputs intact.
   edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (ref_in),
      .rise (ref_rise)
   );

   edge_sync #(.STAGES(SYNC_STAGES)) u_dly_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (dly_in),
      .rise (dly_rise)
   );

   // The sample recorded on a dly edge is the counter after this cycle's
   // increment, so a delay of d cycles between the inputs records d.
   assign cnt_inc  = cnt_q + CNT_WIDTH'(1);
   assign cnt_max  = (cnt_q == '1);
   assign idx_last = (idx_q == '1);

   // Measurement FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         delay_sum <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         case (state_q)
            IDLE: begin
               // A start coinciding with the valid/timeout pulse is dropped.
               if (start && !valid && !timeout) begin
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= WAIT_REF;
               end
            end

            WAIT_REF: begin
               if (ref_rise) begin
                  if (dly_rise) begin
                     // Coincident edges: zero-length sample, accumulator unchanged.
                     idx_q <= idx_q + NAVG_LOG2'(1);
                     if (idx_last) begin
                        state_q <= DONE;
                     end
                  end else begin
                     cnt_q   <= '0;
                     state_q <= COUNT;
                  end
               end
            end

            COUNT: begin
               if (cnt_max) begin
                  // The next sample would exceed the counter range.
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  acc_q   <= '0;
                  state_q <= IDLE;
               end else if (dly_rise) begin
                  acc_q   <= acc_q + SUM_W'(cnt_inc);
                  idx_q   <= idx_q + NAVG_LOG2'(1);
                  state_q <= idx_last ? DONE : WAIT_REF;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end

            DONE: begin
               delay_sum <= acc_q;
               valid     <= 1'b1;
               busy      <= 1'b0;
               state_q   <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter: PWM reference with a programmable delayed copy.
module tb_delay_meter;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ref_in;
   logic        dly_in;
   logic [11:0] delay_sum;
   logic        valid;
   logic        busy;
   logic        timeout;

   int          total = 0;
   int          bad   = 0;

   // Stimulus / observation state
   int          cyc = 0;
   logic [7:0]  pwm = 8'd130;
   logic [15:0] hist = '0;
   int          dmode = 0;    // 0: fixed delay, 1: alternating 3/4, 2: dly held low
   int          dly_d = 0;
   bit          alt_phase = 1'b0;
   logic        prev_ref = 1'b0;
   logic        prev_dly = 1'b0;
   bit          ref_rose = 1'b0;
   bit          dly_rose = 1'b0;
   int          last_dly_rise = 0;
   int          vcount = 0;
   int          tcount = 0;
   int          lat_at_valid = -1;
   int          last_to_cyc = 0;
   logic        busy_at_pulse = 1'bx;

   delay_meter #(
      .SYNC_STAGES (SYNC),
      .NAVG_LOG2   (4),
      .CNT_WIDTH   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ref_in    (ref_in),
      .dly_in    (dly_in),
      .delay_sum (delay_sum),
      .valid     (valid),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: observe outputs #1 after the edge, then drive the next inputs.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (valid) begin
         vcount++;
         lat_at_valid  = cyc - last_dly_rise;
         busy_at_pulse = busy;
      end
      if (timeout) begin
         tcount++;
         last_to_cyc   = cyc;
         busy_at_pulse = busy;
      end
      pwm = pwm + 8'd1;
      if (pwm == 8'd0) alt_phase = ~alt_phase;
      ref_in = (pwm < 8'd128);
      hist   = {hist[14:0], ref_in};
      case (dmode)
         0:       dly_in = hist[dly_d];
         1:       dly_in = alt_phase ? hist[4] : hist[3];
         default: dly_in = 1'b0;
      endcase
      ref_rose = ref_in & ~prev_ref;
      dly_rose = dly_in & ~prev_dly;
      if (dly_rose) last_dly_rise = cyc;
      prev_ref = ref_in;
      prev_dly = dly_in;
   endtask

   task automatic wait_phase();
      for (int i = 0; i < 300 && pwm != 8'd200; i++) step();
   endtask

   task automatic run_measure(input string tag, input int mode, input int d,
                              input int exp_sum, input bit poke);
      int v0;
      int t0;
      bit got;
      wait_phase();
      dmode = mode;
      dly_d = d;
      v0 = vcount;
      t0 = tcount;
      lat_at_valid = -1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      got = 1'b0;
      for (int n = 0; n < 20 * 256 && !got; n++) begin
         if (poke && (n == 700 || n == 2100)) start = 1'b1;
         step();
         start = 1'b0;
         if (vcount != v0 || tcount != t0) got = 1'b1;
      end
      chk({tag, "_valid_cnt"}, 32'(vcount - v0), 32'd1);
      chk({tag, "_timeout_cnt"}, 32'(tcount - t0), 32'd0);
      chk({tag, "_sum"}, 32'(delay_sum), 32'(exp_sum));
      chk({tag, "_latency"}, 32'(lat_at_valid), 32'(SYNC + 2));
      chk({tag, "_busy_at_valid"}, 32'(busy_at_pulse), 32'd0);
      // Start in the valid cycle must be dropped when poking.
      if (poke) start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_valid_pulse_end"}, 32'(valid), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int v0;
      int t0;
      int k;
      int first_ref;
      bit got;

      rst    = 1'b1;
      start  = 1'b0;
      ref_in = 1'b0;
      dly_in = 1'b0;
      repeat (4) step();
      chk("reset_sum", 32'(delay_sum), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_timeout", 32'(timeout), 32'd0);
      rst = 1'b0;
      step();

      // Average delay of 3.5 cycles: 8*3 + 8*4
      run_measure("alt", 1, 0, 56, 1'b0);

      // Delay sweep 0..15 (includes the 0 and 5 cycle cases)
      for (int d = 0; d < 16; d++) begin
         run_measure($sformatf("sweep%0d", d), 0, d, 16 * d, 1'b0);
      end

      // dly held low: timeout 256 cycles after the detected ref edge
      wait_phase();
      dmode = 2;
      v0 = vcount;
      t0 = tcount;
      first_ref = -1;
      start = 1'b1;
      step();
      start = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 800 && !got; n++) begin
         step();
         if (ref_rose && first_ref < 0) first_ref = cyc;
         if (tcount != t0) got = 1'b1;
      end
      chk("to_count", 32'(tcount - t0), 32'd1);
      chk("to_no_valid", 32'(vcount - v0), 32'd0);
      chk("to_latency", 32'(last_to_cyc - first_ref), 32'(256 + SYNC + 1));
      chk("to_busy", 32'(busy_at_pulse), 32'd0);
      chk("to_sum_held", 32'(delay_sum), 32'd240);
      step();
      chk("to_pulse_end", 32'(timeout), 32'd0);

      // Reset after the 7th sample aborts silently
      wait_phase();
      dmode = 0;
      dly_d = 6;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      for (int n = 0; n < 8 * 256 && k < 7; n++) begin
         step();
         if (dly_rose) k++;
      end
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(delay_sum), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      v0 = vcount;
      t0 = tcount;
      repeat (10 * 256) step();
      chk("rst_no_valid", 32'(vcount - v0), 32'd0);
      chk("rst_no_timeout", 32'(tcount - t0), 32'd0);

      // Next run completes; extra starts while busy are ignored
      run_measure("after_rst", 0, 6, 96, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/delay_meter.md
DELAY_METER -- requirements
Module: delay_meter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth applied identically to both async inputs.
REQ-002 Parameter NAVG_LOG2, default 4: number of averaged samples is 2**NAVG_LOG2 (16).
REQ-003 Parameter CNT_WIDTH, default 8: per-sample counter width; maximum count 2**CNT_WIDTH-1 (255).
REQ-004 clk  input  1  single 100 MHz system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin one averaged measurement.
REQ-007 ref_in  input  1  asynchronous reference signal (delay-line input, PWM).
REQ-008 dly_in  input  1  asynchronous delayed signal (delay-line output).
REQ-009 delay_sum  output  CNT_WIDTH+NAVG_LOG2 (12)  sum of 16 per-sample delays in clk cycles; delay_sum/16 is the mean, giving 1/16-cycle resolution.
REQ-010 valid  output  1  one-cycle pulse; delay_sum is updated in the same cycle.
REQ-011 busy  output  1  high from the cycle after an accepted start until valid or timeout.
REQ-012 timeout  output  1  one-cycle pulse when a sample exceeds the maximum count.

Function
REQ-013 ref_in and dly_in shall each pass through SYNC_STAGES flip-flops, followed by one extra register for rising-edge detection; identical paths preserve relative timing.
REQ-014 FSM states: IDLE, WAIT_REF, COUNT, DONE.
REQ-015 IDLE: start=1 -> WAIT_REF; clear accumulator and sample index.
REQ-016 WAIT_REF: ref rising edge -> COUNT with counter cleared to 0.
REQ-017 COUNT: counter increments by 1 each cycle; on a dly rising edge, the current counter value is added to the accumulator, the sample index is incremented, and the FSM returns to WAIT_REF.
REQ-018 WAIT_REF: ref and dly rising edges in the same cycle shall record a sample of 0 and stay in WAIT_REF.
REQ-019 A dly rising edge in WAIT_REF without a ref edge shall be ignored; a ref rising edge in COUNT shall be ignored.
REQ-020 After the 16th sample is accumulated, the FSM shall go to DONE; DONE shall load delay_sum, pulse valid for 1 cycle, then go to IDLE.
REQ-021 COUNT with counter = 255 and no dly edge: pulse timeout, discard the accumulator, leave delay_sum unchanged, go to IDLE.
REQ-022 start while busy shall be ignored.
REQ-023 start in the same cycle as valid or timeout shall be ignored; a new start is accepted only in IDLE.
REQ-024 The accumulator cannot overflow: 16 x 255 = 4080 < 4096.
REQ-025 Latency: valid asserts 2 cycles after the 16th dly edge reaches the edge detector.

Reset
REQ-026 On rst=1 at a clk edge: FSM = IDLE; counter, accumulator, sample index, and synchronizer/edge registers = 0; delay_sum=0, valid=0, busy=0, timeout=0.
REQ-027 rst asserted mid-measurement shall abort without a valid or timeout pulse.
REQ-028 After reset, the first rising edge on either input shall be detected only if the input was low for at least one synchronized cycle; a level already high is not an edge.

Structure
REQ-029 Package delay_meter_pkg shall hold the FSM state enum and the defaults for CNT_WIDTH and NAVG_LOG2.
REQ-030 Sub-module edge_sync (N-stage synchronizer plus rising-edge detector) shall be instantiated twice.

Verification
REQ-031 Bench driving ref_in from an 8-bit free-running PWM (period 256 cycles) on a 100 MHz clock, with dly_in = ref_in delayed by exactly 5 cycles; start -> one valid pulse, delay_sum=80, timeout never.
REQ-032 dly_in = ref_in (zero delay) -> delay_sum=0 and valid after 16 PWM periods.
REQ-033 dly_in delayed by 3.5 cycles on average (alternating 3 and 4 per period) -> delay_sum=56.
REQ-034 dly_in held low -> timeout pulse 256 cycles after the first detected ref edge, busy drops, delay_sum holds its previous value.
REQ-035 rst pulsed after the 7th sample, then start -> no valid from the aborted run; the next run completes with correct delay_sum; start pulses issued while busy have no effect.
REQ-036 Sweep delay 0..15 cycles in 16 runs -> delay_sum = 16 x delay for each run.
